// File: rtl/pwm_capture_peripheral.sv
// Bus-mapped PWM input capture: measures period and high time of pwm_in.
// Define PWM_CAPTURE_DUTY_EN to build the duty-cycle divider.

module pwm_capture_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_1000,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] add,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        wr,
    input  logic        rd,
    output logic        wr_busy,
    output logic        rd_busy,
    input  logic        wr_strobe,
    input  logic        rd_strobe,
    input  logic [3:0]  mask,
    input  logic        pwm_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_HI, S_LO, S_DONE
    } state_t;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_PERIOD = 8'h04;
    localparam logic [7:0] OFF_HIGH   = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_DUTY   = 8'h10;
    localparam logic [CNT_W-1:0] CMAX = '1;

    state_t           state, nxt;
    logic [2:0]       ctrl;
    logic [7:0]       wa, ra;
    logic [2:0]       wd;
    logic             wm;
    logic [31:0]      rdata;
    logic             s1, s2, lvl, lvl_q, rise, fall;
    logic [CNT_W-1:0] cnt, hi_stage, period, high;
    logic             valid, overrun, timeout;
    logic             cnt_clr, cnt_ld1, cnt_inc;
    logic             hi_cap, commit, tmo;
    logic             hit, ctrl_go, clr;
    logic             duty_busy;
    logic [6:0]       duty;
    logic             unused_ok;

    assign unused_ok = ^{wr_strobe, din[31:3], mask[3:1]};

    assign hit     = add[31:8] == BASE_ADDR[31:8];
    assign ctrl_go = wr_busy && wa == OFF_CTRL && wm && wd[0];
    assign clr     = rd_strobe && ra == OFF_STATUS;
    assign lvl     = s2 ^ ctrl[1];
    assign rise    = lvl & ~lvl_q;
    assign fall    = ~lvl & lvl_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_busy <= 1'b0;
            rd_busy <= 1'b0;
            wa      <= '0;
            wd      <= '0;
            wm      <= 1'b0;
            ra      <= '0;
            ctrl    <= '0;
            dout    <= '0;
        end else begin
            if (wr_busy) begin
                wr_busy <= 1'b0;
                if (wa == OFF_CTRL && wm)
                    ctrl <= wd;
            end else if (wr && hit) begin
                wr_busy <= 1'b1;
                wa      <= add[7:0];
                wd      <= din[2:0];
                wm      <= mask[0];
            end
            if (rd_busy) begin
                rd_busy <= 1'b0;
                dout    <= rdata;
            end else if (rd && hit) begin
                rd_busy <= 1'b1;
                ra      <= add[7:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (ra)
            OFF_CTRL:   rdata = {29'd0, ctrl};
            OFF_PERIOD: rdata = 32'(period);
            OFF_HIGH:   rdata = 32'(high);
            OFF_STATUS: rdata = {27'd0, duty_busy, s2,
                                 timeout, overrun, valid};
            OFF_DUTY:   rdata = {25'd0, duty};
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt     = state;
        cnt_clr = 1'b0;
        cnt_ld1 = 1'b0;
        cnt_inc = 1'b0;
        hi_cap  = 1'b0;
        commit  = 1'b0;
        tmo     = 1'b0;
        if (!ctrl[0]) begin
            nxt     = S_IDLE;
            cnt_clr = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: nxt = S_ARM;
                S_ARM: if (rise) begin
                    cnt_ld1 = 1'b1;
                    nxt     = S_HI;
                end
                S_HI: if (fall) begin
                    hi_cap  = 1'b1;
                    cnt_inc = 1'b1;
                    nxt     = S_LO;
                end else if (cnt == CMAX) begin
                    tmo = 1'b1;
                    nxt = S_ARM;
                end else begin
                    cnt_inc = 1'b1;
                end
                S_LO: if (rise) begin
                    commit  = 1'b1;
                    cnt_ld1 = 1'b1;
                    nxt     = ctrl[2] ? S_DONE : S_HI;
                end else if (cnt == CMAX) begin
                    tmo = 1'b1;
                    nxt = S_ARM;
                end else begin
                    cnt_inc = 1'b1;
                end
                S_DONE: if (ctrl_go) nxt = S_ARM;
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            lvl_q    <= 1'b0;
            cnt      <= '0;
            hi_stage <= '0;
            period   <= '0;
            high     <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            s1    <= pwm_in;
            s2    <= s1;
            lvl_q <= lvl;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_ld1) cnt <= CNT_W'(1);
            else if (cnt_inc && cnt != CMAX)
                cnt <= cnt + CNT_W'(1);
            if (hi_cap) hi_stage <= cnt;
            if (commit) begin
                period <= cnt;
                high   <= hi_stage;
            end
            // a flag raised in the clearing cycle survives
            if (commit)   valid <= 1'b1;
            else if (clr) valid <= 1'b0;
            if (commit && valid) overrun <= 1'b1;
            else if (clr)        overrun <= 1'b0;
            if (tmo)      timeout <= 1'b1;
            else if (clr) timeout <= 1'b0;
        end
    end

`ifdef PWM_CAPTURE_DUTY_EN
    localparam int DW = CNT_W + 7;

    logic [DW-1:0]    dq;
    logic [CNT_W-1:0] drem, ddiv;
    logic [CNT_W:0]   dtrial;
    logic [5:0]       dcnt;
    logic             qbit;

    assign dtrial = {drem, dq[DW-1]} - {1'b0, ddiv};
    assign qbit   = ~dtrial[CNT_W];

    // restoring divide of high*100 by period, one quotient bit per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq        <= '0;
            drem      <= '0;
            ddiv      <= '0;
            dcnt      <= '0;
            duty_busy <= 1'b0;
            duty      <= '0;
        end else if (commit) begin
            dq        <= DW'(hi_stage) * DW'(100);
            drem      <= '0;
            ddiv      <= cnt;
            dcnt      <= 6'(DW);
            duty_busy <= 1'b1;
        end else if (duty_busy) begin
            if (qbit) drem <= dtrial[CNT_W-1:0];
            else      drem <= {drem[CNT_W-2:0], dq[DW-1]};
            dq   <= {dq[DW-2:0], qbit};
            dcnt <= dcnt - 6'd1;
            if (dcnt == 6'd1) begin
                duty_busy <= 1'b0;
                duty      <= {dq[5:0], qbit};
            end
        end
    end
`else
    assign duty_busy = 1'b0;
    assign duty      = '0;
`endif

endmodule

// File: tb/tb_pwm_capture_peripheral.sv
// Self-checking bench for pwm_capture_peripheral (CNT_W=16).
// Directed table, randomized periods, oneshot/timeout/reset sequences.

module tb_pwm_capture_peripheral;

    localparam int          CW   = 16;
    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PER  = BASE + 32'h04;
    localparam logic [31:0] A_HIGH = BASE + 32'h08;
    localparam logic [31:0] A_STAT = BASE + 32'h0C;
    localparam logic [31:0] A_DUTY = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] add = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        wr_busy, rd_busy;
    logic        wr_strobe = 1'b0;
    logic        rd_strobe = 1'b0;
    logic [3:0]  mask = '0;
    logic        pwm_in = 1'b0;

    int checks   = 0;
    int failures = 0;

    int   pn = 100;
    int   phi = 50;
    int   ph = 0;
    bit   pwm_on = 1'b0;
    logic idle_lvl = 1'b0;

    typedef struct {
        logic [2:0] ctrl;
        int n;
        int h;
        int e_per;
        int e_hi;
        int e_duty;
    } vec_t;

    vec_t tbl[5];

    pwm_capture_peripheral #(
        .BASE_ADDR(BASE),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .add(add),
        .din(din),
        .dout(dout),
        .wr(wr),
        .rd(rd),
        .wr_busy(wr_busy),
        .rd_busy(rd_busy),
        .wr_strobe(wr_strobe),
        .rd_strobe(rd_strobe),
        .mask(mask),
        .pwm_in(pwm_in)
    );

    always #5 clk = ~clk;

    // ideal PWM source: period pn, high for the first phi cycles
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (pwm_on) begin
                ph = (ph + 1) % pn;
                pwm_in = (ph < phi);
            end else begin
                pwm_in = idle_lvl;
            end
        end
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a,
                             input logic [31:0] d,
                             input logic [3:0] m,
                             output logic b1,
                             output logic b2);
        @(posedge clk);
        #1;
        add = a; din = d; mask = m; wr = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
        b1 = wr_busy;
        @(posedge clk);
        #1;
        b2 = wr_busy;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        logic b1, b2;
        bus_write(a, d, 4'hF, b1, b2);
    endtask

    task automatic bus_read(input logic [31:0] a,
                            output logic [31:0] d);
        @(posedge clk);
        #1;
        add = a; rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        @(posedge clk);
        #1;
        d = dout;
    endtask

    task automatic strobe();
        @(posedge clk);
        #1;
        rd_strobe = 1'b1;
        @(posedge clk);
        #1;
        rd_strobe = 1'b0;
    endtask

    task automatic clear_flags();
        logic [31:0] d;
        bus_read(A_STAT, d);
        strobe();
    endtask

    task automatic start_pwm(input int n, input int h);
        pn = n; phi = h; ph = n - 1;
        pwm_on = 1'b1;
    endtask

    function automatic int model_high(bit inv, int n, int h);
        return inv ? n - h : h;
    endfunction

    function automatic int model_duty(int hi, int n);
        return (hi * 100) / n;
    endfunction

    task automatic run_case(input logic [2:0] c, input int n,
                            input int h, input int e_per,
                            input int e_hi, input int e_duty);
        logic [31:0] d;
        wr32(A_CTRL, {29'd0, c[2:1], 1'b0});
        pwm_on = 1'b0;
        idle_lvl = c[1];
        cycles(10);
        clear_flags();
        wr32(A_CTRL, {29'd0, c});
        start_pwm(n, h);
        cycles(3 * n + 30);
        pwm_on = 1'b0;
        cycles(60);
        bus_read(A_PER, d);
        check($sformatf("period n=%0d", n), d, e_per);
        bus_read(A_HIGH, d);
        check($sformatf("high n=%0d", n), d, e_hi);
        bus_read(A_DUTY, d);
`ifdef PWM_CAPTURE_DUTY_EN
        check($sformatf("duty n=%0d", n), d, e_duty);
`else
        check("duty_absent", d, 0);
`endif
        bus_read(A_STAT, d);
        check("status_ovr", d & 32'h17, 32'h3);
        strobe();
        bus_read(A_STAT, d);
        check("status_clr", d & 32'h17, 32'h0);
    endtask

    initial begin
        logic [31:0] d, prev;
        logic b1, b2;
        int n, h, eh;
        bit inv;

        tbl[0] = '{3'h1, 100, 25, 100, 25, 25};
        tbl[1] = '{3'h3, 100, 25, 100, 75, 75};
        tbl[2] = '{3'h1, 7, 3, 7, 3, 42};
        tbl[3] = '{3'h1, 2, 1, 2, 1, 50};
        tbl[4] = '{3'h3, 10, 9, 10, 1, 10};

        #2;
        check("rst_dout", dout, 0);
        check("rst_wbusy", {31'd0, wr_busy}, 0);
        check("rst_rbusy", {31'd0, rd_busy}, 0);
        cycles(3);
        @(negedge clk);
        rst = 1'b1;

        bus_read(A_CTRL, d);
        check("rst_ctrl", d, 0);
        bus_read(A_STAT, d);
        check("rst_status", d, 0);

        bus_write(A_CTRL, 32'h1, 4'h0, b1, b2);
        check("mask_busy_t1", {31'd0, b1}, 1);
        check("mask_busy_t2", {31'd0, b2}, 0);
        bus_read(A_CTRL, d);
        check("mask_ctrl", d, 0);

        wr32(A_PER, 32'hFFFF);
        bus_read(A_PER, d);
        check("ro_period", d, 0);
        bus_read(BASE + 32'h14, d);
        check("unmapped", d, 0);

        @(posedge clk);
        #1;
        add = 32'h4000_2004; rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        check("nodecode_busy", {31'd0, rd_busy}, 0);

        for (int i = 0; i < 5; i++)
            run_case(tbl[i].ctrl, tbl[i].n, tbl[i].h,
                     tbl[i].e_per, tbl[i].e_hi, tbl[i].e_duty);

        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(4, 200);
            h = $urandom_range(1, n - 1);
            inv = 1'($urandom_range(0, 1));
            eh = model_high(inv, n, h);
            run_case({1'b0, inv, 1'b1}, n, h, n, eh,
                     model_duty(eh, n));
        end

        wr32(A_CTRL, 32'h0);
        idle_lvl = 1'b0;
        cycles(10);
        clear_flags();
        wr32(A_CTRL, 32'h5);
        start_pwm(100, 50);
        cycles(500);
        bus_read(A_STAT, d);
        check("oneshot_one", d & 32'h7, 32'h1);
        bus_read(A_HIGH, d);
        check("oneshot_high", d, 50);
        bus_read(A_STAT, d);
        strobe();
        cycles(300);
        bus_read(A_STAT, d);
        check("oneshot_hold", d & 32'h7, 32'h0);
        wr32(A_CTRL, 32'h5);
        cycles(300);
        bus_read(A_STAT, d);
        check("oneshot_rearm", d & 32'h7, 32'h1);
        pwm_on = 1'b0;

        wr32(A_CTRL, 32'h0);
        cycles(10);
        clear_flags();
        bus_read(A_PER, prev);
        wr32(A_CTRL, 32'h1);
        start_pwm(200000, 10);
        cycles(65400);
        bus_read(A_STAT, d);
        check("tmo_early", d & 32'h4, 32'h0);
        cycles(200);
        bus_read(A_STAT, d);
        check("tmo_set", d & 32'h7, 32'h4);
        bus_read(A_PER, d);
        check("tmo_period", d, prev);
        start_pwm(50, 20);
        cycles(200);
        bus_read(A_PER, d);
        check("tmo_rearm", d, 50);
        pwm_on = 1'b0;

        wr32(A_CTRL, 32'h1);
        start_pwm(100, 90);
        cycles(150);
        @(posedge clk);
        #1;
        add = A_PER; rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        pwm_on = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_dout", dout, 0);
        check("arst_rbusy", {31'd0, rd_busy}, 0);
        check("arst_wbusy", {31'd0, wr_busy}, 0);
        cycles(3);
        @(negedge clk);
        rst = 1'b1;
        bus_read(A_CTRL, d);
        check("arst_ctrl", d, 0);
        bus_read(A_PER, d);
        check("arst_period", d, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture_peripheral.md
# pwm_capture_peripheral

Bus-mapped PWM input-capture peripheral: the receiving end of the PWM generator link. It samples an external PWM signal and measures period and high time in clock cycles. With the duty feature compiled in, it also reports duty cycle in percent. It sits on the same register bus as the PWM generator and serves as the on-chip monitor and loop-back checker for `pwm_out`.

## Interface
- `BASE_ADDR`, 32'h4000_1000: block base address; decode is `add[31:8] == BASE_ADDR[31:8]`.
- `CNT_W`, 32: measurement counter width (16..32).
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-low.
- `add` input 32: bus address.
- `din` input 32: write data.
- `dout` output 32: read data.
- `wr` input 1: one-cycle write request.
- `rd` input 1: one-cycle read request.
- `wr_busy` output 1: write in progress.
- `rd_busy` output 1: read in progress.
- `wr_strobe` input 1: master write acknowledge; accepted but unused.
- `rd_strobe` input 1: master read acknowledge; triggers clear-on-read.
- `mask` input 4: byte enables for writes, bit n covers `din[8n+7:8n]`.
- `pwm_in` input 1: asynchronous PWM input.

## Operation
- Registers (offsets):
  - 0x00 CTRL, RW: bit0 EN, bit1 INV (invert input), bit2 ONESHOT.
  - 0x04 PERIOD, RO.
  - 0x08 HIGH, RO.
  - 0x0C STATUS, RO: bit0 VALID, bit1 OVERRUN, bit2 TIMEOUT, bit3 synchronized input level, bit4 DUTY_BUSY.
  - 0x10 DUTY, RO.
- Unmapped offsets read 0. Writes to RO offsets are ignored. Non-decoded addresses get no response: busy stays 0.
- Input path: 2-flop synchronizer, then XOR with INV, then an edge register producing one-cycle `rise`/`fall` pulses.
- FSM states and transitions:
  - IDLE: entered whenever EN=0; clears the counter.
  - ARM: waits for `rise`, then cnt<=1 and goes to HI.
  - HI: cnt++; on `fall`, hi_stage<=cnt and goes to LO.
  - LO: cnt++; on `rise`, commit (PERIOD<=cnt, HIGH<=hi_stage), then cnt<=1 and go to HI. If ONESHOT, go to DONE instead.
  - DONE: holds until CTRL is written with EN=1.
- Measurement results: input period N cycles with high time H gives PERIOD=N and HIGH=H exactly.
- Counter saturation: cnt saturates at 2^CNT_W-1. On saturation in HI or LO: set TIMEOUT, go to ARM, no commit. PERIOD/HIGH are zero-extended to 32 bits.
- Commit flags: commit sets VALID. If VALID is already 1 at commit, OVERRUN is also set. Registers update regardless.
- Clear-on-read: `rd_strobe` while the last latched read address is STATUS clears VALID, OVERRUN and TIMEOUT. A flag set in the same cycle as the clear wins (stays 1).
- Simultaneous `rise`/`fall` cannot occur; a pulse shorter than 1 cycle may be missed, with no error flagged.

## Timing
- Reset values: all registers and `dout` are 0; `wr_busy` and `rd_busy` are 0; FSM is in IDLE.
- Write handshake:
  - `wr` at cycle t with address hit: add, din and mask are latched.
  - `wr_busy`=1 in cycle t+1; the register updates at the end of t+1.
  - `wr_busy`=0 from t+2.
  - A `wr` while busy is ignored.
- Read handshake:
  - `rd` at cycle t: address latched.
  - `rd_busy`=1 in t+1.
  - `dout` is valid from t+2 and held until the next read completes.
- Input latency: a `pwm_in` edge appears as `rise`/`fall` 3 cycles later. This latency is constant, so measurements are unaffected.
- Disable mid-measurement: clearing EN goes to IDLE next cycle, with no commit. Asynchronous reset mid-operation returns everything to reset values immediately.

## Configuration
- `PWM_CAPTURE_DUTY_EN` defined:
  - A restoring divider computes DUTY = floor(HIGH*100/PERIOD), range 0..100, over CNT_W+7 cycles after each commit.
  - DUTY_BUSY=1 while computing; DUTY keeps its old value until done.
  - A commit during a divide restarts the divide.
  - PERIOD=0 cannot occur.
- Undefined: the divider is absent, the DUTY offset reads 0, and DUTY_BUSY is tied to 0.

## Test plan
- EN=1, `pwm_in` period 100 with high 25 -> after the second rising edge PERIOD=100, HIGH=25, VALID=1. With the macro: DUTY=25 once DUTY_BUSY=0.
- CTRL=0x3 (INV) with the same input -> HIGH=75, PERIOD=100.
- Two commits with no STATUS read -> OVERRUN=1. Then read STATUS plus `rd_strobe` -> the read returns 0x3, and a subsequent read returns VALID=0, OVERRUN=0.
- CNT_W=16, input held low after one rise -> TIMEOUT=1 after 65535 cycles, FSM back in ARM, PERIOD unchanged.
- ONESHOT=1, continuous 50/100 input -> exactly one commit, then VALID remains 0 after clear until CTRL is rewritten.
- Write CTRL=0x1 with mask=4'b0000 -> CTRL stays 0, `wr_busy` is 1 for exactly one cycle. Assert reset mid-HI -> all outputs 0 at once.
